// File: rtl/mem_trace_monitor.sv
// mem_trace_monitor: captures read/write transactions on NCH memory channels
// into per-channel pending registers. A round-robin arbiter moves one pending
// entry per cycle through a one-slot stage into a trace FIFO, and each record
// is stamped with a free-running 16-bit cycle counter.
// Optional feature: define MEM_TRACE_FILTER_EN to add i_lo_addr/i_hi_addr and
// capture only addresses inside [i_lo_addr, i_hi_addr] (unsigned).
//
// Output handshake: o_valid is high while the FIFO holds a record and o_record
// shows the oldest one. The record leaves on a rising edge where o_valid and
// i_ready are both high. While o_valid=1 and i_ready=0, o_record holds steady.
// o_valid never depends combinationally on i_ready.
module mem_trace_monitor #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int REC_W = 16 + CH_W + 1 + ADDR_W + DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NCH*ADDR_W-1:0] i_addr,
    input  logic [NCH*DATA_W-1:0] i_rdata,
    input  logic [NCH*DATA_W-1:0] i_wdata,
    input  logic [NCH-1:0]        i_ren,
    input  logic [NCH-1:0]        i_wen,
`ifdef MEM_TRACE_FILTER_EN
    input  logic [ADDR_W-1:0]     i_lo_addr,
    input  logic [ADDR_W-1:0]     i_hi_addr,
`endif
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [REC_W-1:0]      o_record,
    output logic [15:0]           o_drops
);
    localparam int PW = $clog2(DEPTH);

    logic [15:0]      stamp;
    logic [NCH-1:0]   in_range;
    logic [NCH-1:0]   txn;
    logic [NCH-1:0]   take;
    logic [NCH-1:0]   drop;
    logic [REC_W-1:0] new_rec [NCH];
    logic [NCH-1:0]   pend_v;
    logic [REC_W-1:0] pend_rec [NCH];
    logic [3:0]       drop_n;
    logic [16:0]      drop_sum;

    logic [CH_W-1:0]  prio;
    logic [CH_W-1:0]  gnt_idx;
    logic [CH_W-1:0]  nxt_prio;
    logic             gnt_any;
    logic [NCH-1:0]   gnt_oh;
    logic             can_grant;
    logic             pop;

    // The stage slot counts toward FIFO occupancy, so total storage stays DEPTH.
    logic             stg_v;
    logic [REC_W-1:0] stg_rec;
    logic [REC_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [PW:0]      occ;

    assign o_valid  = (count != '0);
    assign o_record = o_valid ? mem[rd_ptr] : '0;

    // Address window qualification for each channel.
    always_comb begin
        in_range = '1;
`ifdef MEM_TRACE_FILTER_EN
        for (int k = 0; k < NCH; k++) begin
            in_range[k] = (i_addr[k*ADDR_W +: ADDR_W] >= i_lo_addr) &&
                          (i_addr[k*ADDR_W +: ADDR_W] <= i_hi_addr);
        end
`endif
    end

    // Per-channel capture and drop decisions, plus the record to load.
    always_comb begin
        txn    = '0;
        take   = '0;
        drop   = '0;
        drop_n = '0;
        for (int k = 0; k < NCH; k++) begin
            txn[k]  = (i_ren[k] | i_wen[k]) & in_range[k];
            take[k] = txn[k] & (~pend_v[k] | gnt_oh[k]);
            drop[k] = txn[k] & pend_v[k] & ~gnt_oh[k];
            new_rec[k] = {stamp, CH_W'(k), i_wen[k], i_addr[k*ADDR_W +: ADDR_W],
                          i_wen[k] ? i_wdata[k*DATA_W +: DATA_W]
                                   : i_rdata[k*DATA_W +: DATA_W]};
            drop_n = drop_n + {3'b000, drop[k]};
        end
        drop_sum = {1'b0, o_drops} + {13'b0, drop_n};
    end

    // Round-robin grant, searching upward from the channel after the last grant.
    always_comb begin
        logic [CH_W:0] idx_sum;
        idx_sum   = '0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        occ       = count + {{PW{1'b0}}, stg_v};
        pop       = o_valid & i_ready;
        can_grant = (occ < (PW+1)'(DEPTH)) | pop;
        for (int i = 0; i < NCH; i++) begin
            idx_sum = {1'b0, prio} + (CH_W+1)'(i);
            if (idx_sum >= (CH_W+1)'(NCH)) begin
                idx_sum = idx_sum - (CH_W+1)'(NCH);
            end
            if (!gnt_any && can_grant && pend_v[idx_sum[CH_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_sum[CH_W-1:0];
            end
        end
        gnt_oh   = gnt_any ? (NCH'(1) << gnt_idx) : '0;
        nxt_prio = (gnt_idx == CH_W'(NCH-1)) ? '0 : gnt_idx + 1'b1;
    end

    // Free-running stamp counter; wraps from 0xFFFF to 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) stamp <= '0;
        else       stamp <= stamp + 16'd1;
    end

    // Pending flags: set on capture, cleared when granted without a refill.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_v <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (take[k])        pend_v[k] <= 1'b1;
                else if (gnt_oh[k]) pend_v[k] <= 1'b0;
            end
        end
    end

    // Pending payloads; the flags alone decide whether a payload is meaningful.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (take[k]) pend_rec[k] <= new_rec[k];
        end
    end

    // Arbiter priority pointer and stage valid flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prio  <= '0;
            stg_v <= 1'b0;
        end else begin
            stg_v <= gnt_any;
            if (gnt_any) prio <= nxt_prio;
        end
    end

    // Stage payload: the granted pending record.
    always_ff @(posedge i_clk) begin
        if (gnt_any) stg_rec <= pend_rec[gnt_idx];
    end

    // FIFO pointers and occupancy. The stage always has room to drain, because
    // grants are held back once stage plus FIFO reach DEPTH.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (stg_v) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({stg_v, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write.
    always_ff @(posedge i_clk) begin
        if (stg_v) mem[wr_ptr] <= stg_rec;
    end

    // Saturating count of lost transactions.
    always_ff @(posedge i_clk) begin
        if (i_rst)              o_drops <= '0;
        else if (drop_sum[16])  o_drops <= 16'hFFFF;
        else                    o_drops <= drop_sum[15:0];
    end

endmodule

// File: tb/tb_mem_trace_monitor.sv
// Self-checking bench for mem_trace_monitor (NCH=2, 32-bit address/data, DEPTH=16).
// Expected records are queued when a transaction is driven and compared as the
// DUT hands each one over. The address-window scenario is built only when
// MEM_TRACE_FILTER_EN is defined.
module tb_mem_trace_monitor;
    localparam int NCH    = 2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int REC_W  = 16 + 1 + 1 + AW + DW;
    localparam int CH_BIT = AW + DW + 1;

    logic              clk;
    logic              rst;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] rdata;
    logic [NCH*DW-1:0] wdata;
    logic [NCH-1:0]    ren;
    logic [NCH-1:0]    wen;
    logic              valid;
    logic              ready;
    logic [REC_W-1:0]  record;
    logic [15:0]       drops;
`ifdef MEM_TRACE_FILTER_EN
    logic [AW-1:0]     lo_addr;
    logic [AW-1:0]     hi_addr;
`endif

    int               n_checks;
    int               n_fail;
    int               n_pops;
    logic [15:0]      stamp_m;
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] exp_q1[$];
    bit               split_sb;
    bit               hold_v;
    logic [REC_W-1:0] hold_rec;

    mem_trace_monitor #(
        .NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_addr(addr),
        .i_rdata(rdata),
        .i_wdata(wdata),
        .i_ren(ren),
        .i_wen(wen),
`ifdef MEM_TRACE_FILTER_EN
        .i_lo_addr(lo_addr),
        .i_hi_addr(hi_addr),
`endif
        .o_valid(valid),
        .i_ready(ready),
        .o_record(record),
        .o_drops(drops)
    );

    // Clock and time limit
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1, "time limit");
    end

    // One clock cycle. Inputs were set by the caller for the coming edge. At
    // the falling edge the pending handover is scored, then the bench stamp
    // model advances with the rising edge, and strobes return to idle.
    task automatic cycle();
        logic [REC_W-1:0] exp;
        @(negedge clk);
        if (!rst && valid) begin
            if (hold_v) begin
                n_checks++;
                if (record !== hold_rec) begin
                    n_fail++;
                    $display("FAIL hold_stable: got %h required %h", record, hold_rec);
                end
            end
            if (ready) begin
                hold_v = 1'b0;
                n_pops++;
                n_checks++;
                if (split_sb && record[CH_BIT]) begin
                    if (exp_q1.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected_ch1: got %h required none", record);
                    end else begin
                        exp = exp_q1.pop_front();
                        if (record !== exp) begin
                            n_fail++;
                            $display("FAIL sb_record_ch1: got %h required %h", record, exp);
                        end
                    end
                end else begin
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected: got %h required none", record);
                    end else begin
                        exp = exp_q.pop_front();
                        if (record !== exp) begin
                            n_fail++;
                            $display("FAIL sb_record: got %h required %h", record, exp);
                        end
                    end
                end
            end else begin
                hold_v   = 1'b1;
                hold_rec = record;
            end
        end
        @(posedge clk);
        stamp_m = rst ? 16'h0000 : stamp_m + 16'd1;
        #1;
        ren = '0;
        wen = '0;
    endtask

    // Drive one transaction for the coming edge and queue its expected record.
    task automatic drive_txn(input int ch, input logic r, input logic w,
                             input logic [AW-1:0] a, input logic [DW-1:0] rd,
                             input logic [DW-1:0] wd, input bit expect_rec);
        logic [REC_W-1:0] e;
        addr[ch*AW +: AW]  = a;
        rdata[ch*DW +: DW] = rd;
        wdata[ch*DW +: DW] = wd;
        ren[ch] = r;
        wen[ch] = w;
        if (expect_rec) begin
            e = {stamp_m, ch[0], w, a, (w ? wd : rd)};
            if (split_sb && ch == 1) exp_q1.push_back(e);
            else                     exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        ready = 1'b0;
        exp_q.delete();
        exp_q1.delete();
        hold_v = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b0;
    endtask

    // Accept records until every expected one has been seen, then require idle.
    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() + exp_q1.size()) > 0; i++) cycle();
        n_checks++;
        if ((exp_q.size() + exp_q1.size()) != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d records outstanding, required 0",
                     exp_q.size() + exp_q1.size());
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_extra: o_valid=%b required 0", valid);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", valid); end
        n_checks++;
        if (record !== '0) begin n_fail++; $display("FAIL reset_record: got %h required 0", record); end
        n_checks++;
        if (drops !== 16'h0) begin n_fail++; $display("FAIL reset_drops: got %h required 0", drops); end
        cycle();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b required 0", valid); end
    endtask

    task automatic test_single_read();
        do_reset(2);
        ready = 1'b1;
        cycle();
        cycle();
        drive_txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b1);
        cycle();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL latency_t0: o_valid=%b required 0", valid); end
        cycle();
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL latency_t1: o_valid=%b required 0", valid); end
        cycle();
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL latency_t2: o_valid=%b required 1", valid); end
        drain();
    endtask

    task automatic test_simultaneous();
        do_reset(2);
        ready = 1'b1;
        drive_txn(0, 1'b1, 1'b0, 32'h4,   32'h12345678, 32'h0,  1'b1);
        drive_txn(1, 1'b0, 1'b1, 32'h100, 32'h0BADF00D, 32'h55, 1'b1);
        cycle();
        drain();
        n_checks++;
        if (drops !== 16'h0) begin n_fail++; $display("FAIL simul_drops: got %0d required 0", drops); end
    endtask

    task automatic test_both_strobes();
        int pops0;
        do_reset(2);
        ready = 1'b1;
        pops0 = n_pops;
        drive_txn(1, 1'b1, 1'b1, 32'h200, 32'h77, 32'hA5, 1'b1);
        cycle();
        drain();
        n_checks++;
        if (n_pops - pops0 != 1) begin
            n_fail++;
            $display("FAIL both_count: got %0d records required 1", n_pops - pops0);
        end
    endtask

    task automatic test_backpressure();
        do_reset(2);
        ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_txn(0, 1'b1, 1'b0, 32'h1000 + 32'(4*i), $urandom, 32'h0, (i < 17));
            cycle();
        end
        n_checks++;
        if (drops !== 16'd3) begin n_fail++; $display("FAIL bp_drops: got %0d required 3", drops); end
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", valid); end
        for (int i = 0; i < 4; i++) cycle();
        drain();
        n_checks++;
        if (drops !== 16'd3) begin n_fail++; $display("FAIL bp_drops_after: got %0d required 3", drops); end
    endtask

    // Runs straight after the backpressure scenario, so o_drops starts non-zero.
    task automatic test_reset_inflight();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_txn(1, 1'b1, 1'b0, 32'h300 + 32'(i), $urandom, 32'h0, 1'b1);
            cycle();
        end
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b required 1", valid); end
        n_checks++;
        if (drops !== 16'd3) begin n_fail++; $display("FAIL pre_reset_drops: got %0d required 3", drops); end
        rst = 1'b1;
        exp_q.delete();
        hold_v = 1'b0;
        drive_txn(0, 1'b0, 1'b1, 32'h400, 32'h0, 32'h99, 1'b0);
        cycle();
        rst = 1'b0;
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL inflight_valid: got %b required 0", valid); end
        n_checks++;
        if (record !== '0) begin n_fail++; $display("FAIL inflight_record: got %h required 0", record); end
        n_checks++;
        if (drops !== 16'h0) begin n_fail++; $display("FAIL inflight_drops: got %0d required 0", drops); end
        ready = 1'b1;
        drive_txn(0, 1'b1, 1'b0, 32'h500, 32'hCAFE0001, 32'h0, 1'b0);
        exp_q.push_back({16'h0000, 1'b0, 1'b0, 32'h500, 32'hCAFE0001});
        cycle();
        drain();
    endtask

    // Random mixed traffic on both channels; each channel rests at least one
    // cycle between transactions and the total stays below DEPTH, so no loss.
    task automatic test_back_to_back();
        bit last [NCH];
        int total;
        int kind;
        do_reset(2);
        split_sb = 1'b1;
        total = 0;
        for (int ch = 0; ch < NCH; ch++) last[ch] = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            ready = 1'($urandom_range(0, 1));
            for (int ch = 0; ch < NCH; ch++) begin
                if (!last[ch] && total < 14 && $urandom_range(0, 1) == 1) begin
                    kind = $urandom_range(0, 2);
                    drive_txn(ch, (kind != 1), (kind != 0), $urandom, $urandom, $urandom, 1'b1);
                    total++;
                    last[ch] = 1'b1;
                end else begin
                    last[ch] = 1'b0;
                end
            end
            cycle();
        end
        drain();
        split_sb = 1'b0;
        n_checks++;
        if (drops !== 16'h0) begin n_fail++; $display("FAIL b2b_drops: got %0d required 0", drops); end
    endtask

`ifdef MEM_TRACE_FILTER_EN
    task automatic test_filter();
        do_reset(2);
        lo_addr = 32'h1000;
        hi_addr = 32'h1FFF;
        ready = 1'b1;
        drive_txn(0, 1'b0, 1'b1, 32'h0FFC, 32'h0, 32'h11, 1'b0);
        cycle();
        drive_txn(0, 1'b0, 1'b1, 32'h1000, 32'h0, 32'h22, 1'b1);
        cycle();
        drive_txn(0, 1'b0, 1'b1, 32'h2000, 32'h0, 32'h33, 1'b0);
        cycle();
        drive_txn(1, 1'b1, 1'b0, 32'h1FFF, 32'h44, 32'h0, 1'b1);
        cycle();
        drain();
        n_checks++;
        if (drops !== 16'h0) begin n_fail++; $display("FAIL filter_drops: got %0d required 0", drops); end
        lo_addr = '0;
        hi_addr = '1;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_pops   = 0;
        stamp_m  = 16'h0;
        split_sb = 1'b0;
        hold_v   = 1'b0;
        hold_rec = '0;
        rst      = 1'b1;
        ready    = 1'b0;
        ren      = '0;
        wen      = '0;
        addr     = '0;
        rdata    = '0;
        wdata    = '0;
`ifdef MEM_TRACE_FILTER_EN
        lo_addr  = '0;
        hi_addr  = '1;
`endif
        test_reset();
        test_single_read();
        test_simultaneous();
        test_both_strobes();
        test_backpressure();
        test_reset_inflight();
        test_back_to_back();
`ifdef MEM_TRACE_FILTER_EN
        test_filter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
